hazard_ctrl_mc: RTL and testbench

Second-generation hazard controller for the 5-stage MIPS pipeline, generalised for a multi-cycle multiply/divide unit (MDU) and parametrised register-file width.
- Detects load-use hazards, with a precise store-data exemption.
- Tracks MDU occupancy with a countdown and stalls HI/LO readers and back-to-back MDU ops.
- Generates multi-cycle flushes on taken branches/jumps resolved in EX.
- Keeps saturating stall/flush performance counters.
- Sits beside the IF/ID and ID/EX pipeline registers and drives their hold/flush controls.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/sat_counter.sv | 27 ++
 rtl/hazard_ctrl_mc.sv | 105 ++++++++++
 tb/tb_hazard_ctrl_mc.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the MIPS hazard controller: MDU latency
// defaults, the hard-wired zero register, and the redirect cause.
package hazard_pkg;

  localparam int unsigned MUL_LAT_DEF = 3;
  localparam int unsigned DIV_LAT_DEF = 8;
  localparam int unsigned ZERO_REG    = 0;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_JUMP   = 2'd2
  } redirect_e;

  // A jump outranks a branch when both are flagged in EX.
  function automatic redirect_e redirectCause(input logic jump, input logic branch,
                                              input logic cond);
    if (jump)                return REDIR_JUMP;
    else if (branch && cond) return REDIR_BRANCH;
    else                     return REDIR_NONE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment)
// and asynchronous active-low reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage MIPS pipeline with a multi-cycle MDU:
// load-use and MDU stalls, held flushes on EX redirects, perf counters.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W        = 5,
  parameter int unsigned MUL_LAT      = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT      = DIV_LAT_DEF,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter bit          STORE_FWD    = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_mem_write,
  input  logic             id_is_mdu,
  input  logic             id_reads_hilo,
  input  logic             ex_mem_to_reg,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_jump,
  input  logic             ex_branch,
  input  logic             ex_cond,
  input  logic             mdu_start,
  input  logic             mdu_is_div,
  input  logic             perf_clr,
  output logic             stall,
  output logic             flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned MDU_W = $clog2(DIV_LAT + 1);
  localparam int unsigned FL_W  = $clog2(FLUSH_CYCLES + 1);

  logic [MDU_W-1:0] r_mduCnt;
  logic [FL_W-1:0]  r_flushCnt;
  logic             w_loadDestValid;
  logic             w_luRs;
  logic             w_luRt;
  logic             w_mduHz;
  logic             w_taken;
  redirect_e        w_cause;

  // A store whose only dependence is its data operand can pick the value up
  // later through the MEM forwarding path, so it need not stall.
  assign w_loadDestValid = ex_mem_to_reg && (ex_rt != REG_W'(ZERO_REG));
  assign w_luRs  = w_loadDestValid && id_uses_rs && (id_rs == ex_rt);
  assign w_luRt  = w_loadDestValid && id_uses_rt && (id_rt == ex_rt)
                   && !(STORE_FWD && id_mem_write);
  assign w_mduHz = (id_is_mdu || id_reads_hilo) && ((r_mduCnt != '0) || mdu_start);

  assign w_cause = redirectCause(ex_jump, ex_branch, ex_cond);
  assign w_taken = ex_jump || (ex_branch && ex_cond);

  assign flush    = w_taken || (r_flushCnt != '0);
  assign stall    = (w_luRs || w_luRt || w_mduHz) && !flush;
  assign mdu_busy = (r_mduCnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mduCnt <= '0;
    end else if (mdu_start) begin
      r_mduCnt <= mdu_is_div ? MDU_W'(DIV_LAT) : MDU_W'(MUL_LAT);
    end else if (r_mduCnt != '0) begin
      r_mduCnt <= r_mduCnt - 1'b1;
    end
  end

  // The combinational taken cycle is the first flush cycle; the register
  // only covers the remaining FLUSH_CYCLES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flushCnt <= '0;
    end else if (w_taken) begin
      r_flushCnt <= FL_W'(FLUSH_CYCLES - 1);
    end else if (r_flushCnt != '0) begin
      r_flushCnt <= r_flushCnt - 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (stall),
    .i_clr   (perf_clr),
    .o_count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flushCnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_taken),
    .i_clr   (perf_clr),
    .o_count (flush_cnt)
  );

  assert property (@(posedge clk) disable iff (!rst_n)
                   (w_cause != REDIR_NONE) |-> (flush && !stall));

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: a default instance and a variant with
// STORE_FWD=0, FLUSH_CYCLES=2, CNT_W=4 share one directed stimulus stream.
module tb_hazard_ctrl_mc;

  typedef struct packed {
    logic       rstN;
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic       usesRs;
    logic       usesRt;
    logic       memWrite;
    logic       isMdu;
    logic       readsHilo;
    logic       memToReg;
    logic [4:0] exRt;
    logic       jump;
    logic       branch;
    logic       cond;
    logic       mduStart;
    logic       mduIsDiv;
    logic       perfClr;
  } vec_t;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        busy;
    logic [15:0] sc;
    logic [15:0] fc;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rs, id_uses_rt, id_mem_write, id_is_mdu, id_reads_hilo;
  logic ex_mem_to_reg, ex_jump, ex_branch, ex_cond, mdu_start, mdu_is_div, perf_clr;
  logic stallA, flushA, busyA, stallB, flushB, busyB;
  logic [15:0] stallCntA, flushCntA;
  logic [3:0]  stallCntB, flushCntB;

  exp_t expQ[$];
  int   nVectors = 0;
  int   nCompares = 0;
  int   nMiscompares = 0;

  hazard_ctrl_mc dutA (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_mem_write(id_mem_write),
    .id_is_mdu(id_is_mdu), .id_reads_hilo(id_reads_hilo), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_rt(ex_rt), .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_cond(ex_cond),
    .mdu_start(mdu_start), .mdu_is_div(mdu_is_div), .perf_clr(perf_clr),
    .stall(stallA), .flush(flushA), .mdu_busy(busyA),
    .stall_cnt(stallCntA), .flush_cnt(flushCntA)
  );

  hazard_ctrl_mc #(.STORE_FWD(1'b0), .FLUSH_CYCLES(2), .CNT_W(4)) dutB (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_mem_write(id_mem_write),
    .id_is_mdu(id_is_mdu), .id_reads_hilo(id_reads_hilo), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_rt(ex_rt), .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_cond(ex_cond),
    .mdu_start(mdu_start), .mdu_is_div(mdu_is_div), .perf_clr(perf_clr),
    .stall(stallB), .flush(flushB), .mdu_busy(busyB),
    .stall_cnt(stallCntB), .flush_cnt(flushCntB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t mk(input logic s, input logic f, input logic b,
                              input int sc, input int fc);
    obs_t o;
    o.stall = s;
    o.flush = f;
    o.busy  = b;
    o.sc    = 16'(sc);
    o.fc    = 16'(fc);
    return o;
  endfunction

  function automatic vec_t idleVec();
    vec_t v;
    v = '0;
    v.rstN = 1'b1;
    return v;
  endfunction

  function automatic vec_t loadUseRs();
    vec_t v;
    v = idleVec();
    v.memToReg = 1'b1;
    v.exRt     = 5'd8;
    v.idRs     = 5'd8;
    v.usesRs   = 1'b1;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input obs_t ea, input obs_t eb);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n         = v.rstN;
    id_rs         = v.idRs;
    id_rt         = v.idRt;
    id_uses_rs    = v.usesRs;
    id_uses_rt    = v.usesRt;
    id_mem_write  = v.memWrite;
    id_is_mdu     = v.isMdu;
    id_reads_hilo = v.readsHilo;
    ex_mem_to_reg = v.memToReg;
    ex_rt         = v.exRt;
    ex_jump       = v.jump;
    ex_branch     = v.branch;
    ex_cond       = v.cond;
    mdu_start     = v.mduStart;
    mdu_is_div    = v.mduIsDiv;
    perf_clr      = v.perfClr;
    e.a = ea;
    e.b = eb;
    expQ.push_back(e);
    nVectors++;
  endtask

  task automatic checkOutput(input int vecIdx, input string name,
                             input int actual, input int required);
    nCompares++;
    if (actual != required) begin
      nMiscompares++;
      $display("[TB] FAIL vec %0d %s: got %0d, expected %0d", vecIdx, name, actual, required);
    end
  endtask

  // Monitor: outputs are valid every cycle once a vector is in flight.
  initial begin
    exp_t e;
    int   idx;
    idx = 0;
    forever begin
      @(negedge clk);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput(idx, "A.stall",     int'(stallA),    int'(e.a.stall));
        checkOutput(idx, "A.flush",     int'(flushA),    int'(e.a.flush));
        checkOutput(idx, "A.mdu_busy",  int'(busyA),     int'(e.a.busy));
        checkOutput(idx, "A.stall_cnt", int'(stallCntA), int'(e.a.sc));
        checkOutput(idx, "A.flush_cnt", int'(flushCntA), int'(e.a.fc));
        checkOutput(idx, "B.stall",     int'(stallB),    int'(e.b.stall));
        checkOutput(idx, "B.flush",     int'(flushB),    int'(e.b.flush));
        checkOutput(idx, "B.mdu_busy",  int'(busyB),     int'(e.b.busy));
        checkOutput(idx, "B.stall_cnt", int'(stallCntB), int'(e.b.sc));
        checkOutput(idx, "B.flush_cnt", int'(flushCntB), int'(e.b.fc));
        idx++;
      end
    end
  end

  initial begin
    vec_t v;
    rst_n = 1'b0;
    {id_rs, id_rt, ex_rt} = '0;
    {id_uses_rs, id_uses_rt, id_mem_write, id_is_mdu, id_reads_hilo} = '0;
    {ex_mem_to_reg, ex_jump, ex_branch, ex_cond, mdu_start, mdu_is_div, perf_clr} = '0;

    v = idleVec(); v.rstN = 1'b0;
    applyStimulus(v, mk(0,0,0,0,0), mk(0,0,0,0,0));
    applyStimulus(idleVec(), mk(0,0,0,0,0), mk(0,0,0,0,0));

    applyStimulus(loadUseRs(), mk(1,0,0,0,0), mk(1,0,0,0,0));
    applyStimulus(idleVec(),   mk(0,0,0,1,0), mk(0,0,0,1,0));

    // Store data dependence only: exempt in A, stalls in B.
    v = idleVec(); v.memToReg = 1; v.exRt = 5'd9; v.idRt = 5'd9; v.idRs = 5'd3;
    v.usesRs = 1; v.usesRt = 1; v.memWrite = 1;
    applyStimulus(v, mk(0,0,0,1,0), mk(1,0,0,1,0));
    v.idRs = 5'd9;
    applyStimulus(v, mk(1,0,0,1,0), mk(1,0,0,2,0));

    v = idleVec(); v.memToReg = 1; v.exRt = 5'd0; v.idRs = 5'd0; v.usesRs = 1;
    applyStimulus(v, mk(0,0,0,2,0), mk(0,0,0,3,0));

    v = loadUseRs(); v.branch = 1; v.cond = 1;
    applyStimulus(v, mk(0,1,0,2,0), mk(0,1,0,3,0));
    applyStimulus(idleVec(), mk(0,0,0,2,1), mk(0,1,0,3,1));
    applyStimulus(idleVec(), mk(0,0,0,2,1), mk(0,0,0,3,1));

    v = idleVec(); v.jump = 1;
    applyStimulus(v, mk(0,1,0,2,1), mk(0,1,0,3,1));
    v = idleVec(); v.branch = 1; v.cond = 1;
    applyStimulus(v, mk(0,1,0,2,2), mk(0,1,0,3,2));
    applyStimulus(loadUseRs(), mk(1,0,0,2,3), mk(0,1,0,3,3));
    applyStimulus(idleVec(), mk(0,0,0,3,3), mk(0,0,0,3,3));
    v = idleVec(); v.branch = 1; v.cond = 0;
    applyStimulus(v, mk(0,0,0,3,3), mk(0,0,0,3,3));

    // Divide followed by a held mfhi: start cycle plus eight busy cycles.
    v = idleVec(); v.mduStart = 1; v.mduIsDiv = 1; v.readsHilo = 1;
    applyStimulus(v, mk(1,0,0,3,3), mk(1,0,0,3,3));
    v = idleVec(); v.readsHilo = 1;
    for (int k = 0; k < 8; k++)
      applyStimulus(v, mk(1,0,1,4+k,3), mk(1,0,1,4+k,3));
    applyStimulus(v, mk(0,0,0,12,3), mk(0,0,0,12,3));

    v = idleVec(); v.mduStart = 1;
    applyStimulus(v, mk(0,0,0,12,3), mk(0,0,0,12,3));
    v = idleVec(); v.isMdu = 1;
    applyStimulus(v, mk(1,0,1,12,3), mk(1,0,1,12,3));
    applyStimulus(idleVec(), mk(0,0,1,13,3), mk(0,0,1,13,3));
    applyStimulus(idleVec(), mk(0,0,1,13,3), mk(0,0,1,13,3));
    applyStimulus(idleVec(), mk(0,0,0,13,3), mk(0,0,0,13,3));

    // Divide in flight, then reset when the countdown reaches 4.
    v = idleVec(); v.mduStart = 1; v.mduIsDiv = 1;
    applyStimulus(v, mk(0,0,0,13,3), mk(0,0,0,13,3));
    for (int k = 0; k < 4; k++)
      applyStimulus(idleVec(), mk(0,0,1,13,3), mk(0,0,1,13,3));
    v = idleVec(); v.rstN = 1'b0;
    applyStimulus(v, mk(0,0,0,0,0), mk(0,0,0,0,0));

    applyStimulus(loadUseRs(), mk(1,0,0,0,0), mk(1,0,0,0,0));
    v = loadUseRs(); v.perfClr = 1;
    applyStimulus(v, mk(1,0,0,1,0), mk(1,0,0,1,0));
    applyStimulus(idleVec(), mk(0,0,0,0,0), mk(0,0,0,0,0));

    for (int i = 0; i < 17; i++)
      applyStimulus(loadUseRs(), mk(1,0,0,i,0), mk(1,0,0,(i > 15) ? 15 : i,0));
    applyStimulus(idleVec(), mk(0,0,0,17,0), mk(0,0,0,15,0));

    @(posedge clk);
    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      nMiscompares++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
